// File: rtl/ball_phys_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ball_phys_pkg                                            |
// | Description : Fixed-point widths, types and helpers shared by the      |
// |               ball physics engine and its per-axis integrators.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package ball_phys_pkg;

  // Default fixed-point format: 12 signed integer bits, 4 fraction bits.
  localparam int FX_INT_W  = 12;
  localparam int FX_FRAC_W = 4;
  localparam int FX_W      = FX_INT_W + FX_FRAC_W;

  typedef logic signed [FX_W-1:0] fx_t;

  // Headroom type for intermediate sums so nothing wraps before clamping.
  typedef logic signed [31:0] wide_t;

  // Clamp a velocity into [-lim, +lim].
  function automatic wide_t sat_fx(input wide_t v, input wide_t lim);
    if (v > lim) begin
      return lim;
    end else if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

  // Reflected speed after a lossy bounce; shift of 0 disables the loss.
  function automatic wide_t damp_fx(input wide_t mag, input int shift);
    if (shift == 0) begin
      return mag;
    end
    return mag - (mag >>> shift);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ball_axis_integrator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ball_axis_integrator                                     |
// | Description : One axis of the ball: integrates acceleration into       |
// |               velocity and position, saturates velocity and reflects   |
// |               off the two walls with damping.                          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ball_axis_integrator
  import ball_phys_pkg::*;
#(
  parameter int DIM         = 800,
  parameter int BALL_RADIUS = 20,
  parameter int VEL_MAX     = 64,
  parameter int DAMP_SHIFT  = 2,
  parameter int INT_W       = 12,
  parameter int FRAC_W      = 4
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic                            step_en,
  input  logic                            recenter,
  input  logic signed [7:0]               accel,
  output logic signed [INT_W+FRAC_W-1:0]  pos,
  output logic signed [INT_W+FRAC_W-1:0]  vel,
  output logic                            bounce
);

  localparam int FW = INT_W + FRAC_W;

  localparam wide_t C_LO   = wide_t'(BALL_RADIUS * (1 << FRAC_W));
  localparam wide_t C_HI   = wide_t'((DIM - BALL_RADIUS) * (1 << FRAC_W));
  localparam wide_t C_CTR  = wide_t'((DIM / 2) * (1 << FRAC_W));
  localparam wide_t C_VMAX = wide_t'(VEL_MAX * (1 << FRAC_W));

  logic signed [FW-1:0] pos_q, pos_d;
  logic signed [FW-1:0] vel_q, vel_d;

  wide_t w_pos, w_vel, w_acc, w_p, w_v, w_mag, w_reb, w_ctr;
  logic  w_hit_lo, w_hit_hi;

  // Candidate next state: free flight, or clamp to a wall and reflect.
  always_comb begin
    w_pos    = wide_t'(pos_q);
    w_vel    = wide_t'(vel_q);
    w_acc    = wide_t'(accel);
    w_ctr    = C_CTR;
    w_p      = w_pos + w_vel;
    w_v      = sat_fx(w_vel + w_acc, C_VMAX);
    w_mag    = (w_vel < 0) ? -w_vel : w_vel;
    w_reb    = damp_fx(w_mag, DAMP_SHIFT);
    w_hit_lo = (w_p < C_LO);
    w_hit_hi = !w_hit_lo && (w_p > C_HI);
    bounce   = w_hit_lo || w_hit_hi;

    pos_d = pos_q;
    vel_d = vel_q;
    if (recenter) begin
      pos_d = w_ctr[FW-1:0];
      vel_d = '0;
    end else if (step_en) begin
      if (w_hit_lo) begin
        pos_d = C_LO[FW-1:0];
        vel_d = w_reb[FW-1:0];
      end else if (w_hit_hi) begin
        w_reb = -w_reb;
        pos_d = C_HI[FW-1:0];
        vel_d = w_reb[FW-1:0];
      end else begin
        pos_d = w_p[FW-1:0];
        vel_d = w_v[FW-1:0];
      end
    end
  end

  // Position/velocity state, ball parked at the centre on reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pos_q <= C_CTR[FW-1:0];
      vel_q <= '0;
    end else begin
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  end

  assign pos = pos_q;
  assign vel = vel_q;

endmodule
`default_nettype wire

// File: rtl/ball_physics_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ball_physics_engine                                      |
// | Description : Two-axis sub-pixel ball integrator with a physics-step   |
// |               divider, freeze/recenter control and step/bounce pulses. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ball_physics_engine
  import ball_phys_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_RADIUS   = 20,
  parameter int INT_W         = 12,
  parameter int FRAC_W        = 4,
  parameter int VEL_MAX       = 64,
  parameter int DAMP_SHIFT    = 2,
  parameter int TICK_DIV      = 8388608
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic signed [7:0] i_accel_x,
  input  logic signed [7:0] i_accel_y,
  input  logic              i_freeze,
  input  logic              i_recenter,
  output logic [9:0]        o_ball_x,
  output logic [9:0]        o_ball_y,
  output logic              o_tick,
  output logic              o_bounce_x,
  output logic              o_bounce_y
);

  localparam int FW    = INT_W + FRAC_W;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             bounce_x_q, bounce_x_d;
  logic             bounce_y_q, bounce_y_d;

  logic                 w_step;
  logic                 w_bounce_x, w_bounce_y;
  logic signed [FW-1:0] w_pos_x, w_pos_y, w_vel_x, w_vel_y;
  logic                 w_unused;

  // Step divider and pulse generation; recenter beats both step and freeze.
  always_comb begin
    w_step     = !i_freeze && !i_recenter && (cnt_q == C_CNT_LAST);
    cnt_d      = cnt_q;
    if (i_recenter) begin
      cnt_d = '0;
    end else if (!i_freeze) begin
      cnt_d = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d     = w_step;
    bounce_x_d = w_step && w_bounce_x;
    bounce_y_d = w_step && w_bounce_y;
  end

  // Counter and one-cycle event pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      bounce_x_q <= bounce_x_d;
      bounce_y_q <= bounce_y_d;
    end
  end

  ball_axis_integrator #(
    .DIM(SCREEN_WIDTH), .BALL_RADIUS(BALL_RADIUS), .VEL_MAX(VEL_MAX),
    .DAMP_SHIFT(DAMP_SHIFT), .INT_W(INT_W), .FRAC_W(FRAC_W)
  ) u_axis_x (
    .clk(clk), .arst_n(arst_n), .step_en(w_step), .recenter(i_recenter),
    .accel(i_accel_x), .pos(w_pos_x), .vel(w_vel_x), .bounce(w_bounce_x)
  );

  ball_axis_integrator #(
    .DIM(SCREEN_HEIGHT), .BALL_RADIUS(BALL_RADIUS), .VEL_MAX(VEL_MAX),
    .DAMP_SHIFT(DAMP_SHIFT), .INT_W(INT_W), .FRAC_W(FRAC_W)
  ) u_axis_y (
    .clk(clk), .arst_n(arst_n), .step_en(w_step), .recenter(i_recenter),
    .accel(i_accel_y), .pos(w_pos_y), .vel(w_vel_y), .bounce(w_bounce_y)
  );

  // Integer pixel part of the registered positions.
  assign o_ball_x   = w_pos_x[FRAC_W+9:FRAC_W];
  assign o_ball_y   = w_pos_y[FRAC_W+9:FRAC_W];
  assign o_tick     = tick_q;
  assign o_bounce_x = bounce_x_q;
  assign o_bounce_y = bounce_y_q;

  // Velocity and fraction/sign bits are internal only.
  assign w_unused = ^{w_vel_x, w_vel_y, w_pos_x, w_pos_y};

endmodule
`default_nettype wire
